// File: rtl/whack_mole_game_if.sv
`default_nettype none
// ============================================================================
// Module   : whack_mole_game_if
// Purpose  : Keyboard-event input and board-display output bundle for the
//            whack-a-mole game controller.
// Revision : 1.0
// ============================================================================
interface whack_mole_game_if;
    logic [15:0] keycode;
    logic        oflag;
    logic [7:0]  light;
    logic [7:0]  score;
    logic [7:0]  misses;
    logic [7:0]  round;
    logic        game_over;

    // The key source (PS/2 receiver or bench) is the master.
    modport master (
        output keycode, oflag,
        input  light, score, misses, round, game_over
    );

    modport slave (
        input  keycode, oflag,
        output light, score, misses, round, game_over
    );
endinterface
`default_nettype wire

// File: rtl/whack_mole_game.sv
`default_nettype none
// ============================================================================
// Module   : whack_mole_game
// Purpose  : Whack-a-mole game controller driven by PS/2 make codes.
// Revision : 1.0
// ============================================================================
module whack_mole_game #(
    parameter int MOLE_TICKS  = 50_000_000,
    parameter int PAUSE_TICKS = 12_500_000,
    parameter int ROUNDS      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    whack_mole_game_if.slave   bus
);

    localparam int MAX_TICKS = (MOLE_TICKS > PAUSE_TICKS) ? MOLE_TICKS : PAUSE_TICKS;
    localparam int TIMER_W   = $clog2(MAX_TICKS);

    localparam logic [TIMER_W-1:0] MOLE_LOAD   = TIMER_W'(MOLE_TICKS - 1);
    localparam logic [TIMER_W-1:0] PAUSE_LOAD  = TIMER_W'(PAUSE_TICKS - 1);
    localparam logic [7:0]         ROUNDS_LAST = 8'(ROUNDS);
    localparam logic [15:0]        LFSR_SEED   = 16'hACE1;
    localparam logic [15:0]        LFSR_MASK   = 16'hB400;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SPAWN = 3'd1;
    localparam logic [2:0] ST_UP    = 3'd2;
    localparam logic [2:0] ST_HIT   = 3'd3;
    localparam logic [2:0] ST_MISS  = 3'd4;
    localparam logic [2:0] ST_OVER  = 3'd5;

    logic [2:0]         state_q,      state_d;
    logic [15:0]        lfsr_q,       lfsr_d;
    logic [TIMER_W-1:0] timer_q,      timer_d;
    logic [2:0]         mole_q,       mole_d;
    logic               prev_valid_q, prev_valid_d;
    logic [7:0]         score_q,      score_d;
    logic [7:0]         misses_q,     misses_d;
    logic [7:0]         round_q,      round_d;
    logic [7:0]         light_q,      light_d;
    logic               game_over_q,  game_over_d;

    logic       make_ev;
    logic       start_ev;
    logic       key_is_mole;
    logic [2:0] key_mole;
    logic [2:0] spawn_idx;
    logic [7:0] round_next;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Break codes (previous byte F0) never count as key presses.
    always_comb begin
        make_ev     = bus.oflag && (bus.keycode[15:8] != 8'hF0);
        start_ev    = make_ev && (bus.keycode[7:0] == 8'h29);
        key_is_mole = make_ev;
        key_mole    = 3'd0;
        case (bus.keycode[7:0])
            8'h16:   key_mole = 3'd0;
            8'h1E:   key_mole = 3'd1;
            8'h26:   key_mole = 3'd2;
            8'h25:   key_mole = 3'd3;
            8'h2E:   key_mole = 3'd4;
            8'h36:   key_mole = 3'd5;
            8'h3D:   key_mole = 3'd6;
            8'h3E:   key_mole = 3'd7;
            default: key_is_mole = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        lfsr_d       = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_MASK) : (lfsr_q >> 1);
        timer_d      = timer_q;
        mole_d       = mole_q;
        prev_valid_d = prev_valid_q;
        score_d      = score_q;
        misses_d     = misses_q;
        round_d      = round_q;
        spawn_idx    = lfsr_q[2:0];
        round_next   = round_q + 8'd1;

        case (state_q)
            ST_IDLE: begin
                if (start_ev) begin
                    state_d = ST_SPAWN;
                end
            end
            ST_SPAWN: begin
                // Never show the same mole twice in a row; 3-bit add wraps 7 to 0.
                if (prev_valid_q && (spawn_idx == mole_q)) begin
                    spawn_idx = spawn_idx + 3'd1;
                end
                mole_d       = spawn_idx;
                prev_valid_d = 1'b1;
                timer_d      = MOLE_LOAD;
                state_d      = ST_UP;
            end
            ST_UP: begin
                if (key_is_mole && (key_mole == mole_q)) begin
                    score_d = sat_inc(score_q);
                    timer_d = PAUSE_LOAD;
                    state_d = ST_HIT;
                end else if (key_is_mole || (timer_q == '0)) begin
                    misses_d = sat_inc(misses_q);
                    timer_d  = PAUSE_LOAD;
                    state_d  = ST_MISS;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_HIT, ST_MISS: begin
                if (timer_q == '0) begin
                    round_d = round_next;
                    state_d = (round_next == ROUNDS_LAST) ? ST_OVER : ST_SPAWN;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_OVER: begin
                if (start_ev) begin
                    score_d      = 8'd0;
                    misses_d     = 8'd0;
                    round_d      = 8'd0;
                    prev_valid_d = 1'b0;
                    state_d      = ST_SPAWN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state view so they track state_q.
    always_comb begin
        light_d     = 8'h00;
        game_over_d = (state_d == ST_OVER);
        case (state_d)
            ST_UP:   light_d = 8'd1 << mole_d;
            ST_HIT:  light_d = 8'hFF;
            ST_OVER: light_d = score_d;
            default: light_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            lfsr_q       <= LFSR_SEED;
            timer_q      <= '0;
            mole_q       <= 3'd0;
            prev_valid_q <= 1'b0;
            score_q      <= 8'd0;
            misses_q     <= 8'd0;
            round_q      <= 8'd0;
            light_q      <= 8'h00;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            timer_q      <= timer_d;
            mole_q       <= mole_d;
            prev_valid_q <= prev_valid_d;
            score_q      <= score_d;
            misses_q     <= misses_d;
            round_q      <= round_d;
            light_q      <= light_d;
            game_over_q  <= game_over_d;
        end
    end

    assign bus.light     = light_q;
    assign bus.score     = score_q;
    assign bus.misses    = misses_q;
    assign bus.round     = round_q;
    assign bus.game_over = game_over_q;

endmodule
`default_nettype wire

// File: tb/tb_whack_mole_game.sv
`default_nettype none
// ============================================================================
// Module   : tb_whack_mole_game
// Purpose  : Self-checking bench for whack_mole_game with a phase-level model.
// Revision : 1.0
// ============================================================================
module tb_whack_mole_game;

    localparam int MOLE_TICKS  = 20;
    localparam int PAUSE_TICKS = 4;
    localparam int ROUNDS      = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    whack_mole_game_if bus ();

    whack_mole_game #(
        .MOLE_TICKS  (MOLE_TICKS),
        .PAUSE_TICKS (PAUSE_TICKS),
        .ROUNDS      (ROUNDS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef enum int {P_IDLE, P_SPAWN, P_UP, P_HIT, P_MISS, P_OVER} phase_t;

    logic [7:0] mole_keys [8] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E};

    phase_t      m_phase;
    int          m_elapsed;
    int          m_mole;
    bit          m_has_prev;
    logic [15:0] m_lfsr;
    logic [7:0]  m_score, m_misses, m_round;

    function automatic int mole_of(input logic [7:0] k);
        for (int i = 0; i < 8; i++) if (mole_keys[i] == k) return i;
        return -1;
    endfunction

    function automatic logic [15:0] galois(input logic [15:0] x);
        return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    endfunction

    function automatic logic [7:0] exp_light();
        case (m_phase)
            P_UP:    return 8'd1 << m_mole;
            P_HIT:   return 8'hFF;
            P_OVER:  return m_score;
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE; m_elapsed = 0; m_mole = 0; m_has_prev = 0;
        m_lfsr = 16'hACE1; m_score = 0; m_misses = 0; m_round = 0;
    endtask

    task automatic model_step(input logic [15:0] kc, input logic fl);
        bit          ev    = fl && (kc[15:8] != 8'hF0);
        int          km    = ev ? mole_of(kc[7:0]) : -1;
        bit          space = ev && (kc[7:0] == 8'h29);
        logic [15:0] cur   = m_lfsr;
        int          pick;
        m_lfsr = galois(cur);
        case (m_phase)
            P_IDLE: if (space) m_phase = P_SPAWN;
            P_SPAWN: begin
                pick = int'(cur[2:0]);
                if (m_has_prev && pick == m_mole) pick = (pick + 1) % 8;
                m_mole = pick; m_has_prev = 1; m_elapsed = 0; m_phase = P_UP;
            end
            P_UP: begin
                m_elapsed++;
                if (km == m_mole) begin
                    if (m_score != 8'hFF) m_score++;
                    m_phase = P_HIT; m_elapsed = 0;
                end else if (km >= 0 || m_elapsed == MOLE_TICKS) begin
                    if (m_misses != 8'hFF) m_misses++;
                    m_phase = P_MISS; m_elapsed = 0;
                end
            end
            P_HIT, P_MISS: begin
                m_elapsed++;
                if (m_elapsed == PAUSE_TICKS) begin
                    m_round++;
                    m_phase = (int'(m_round) == ROUNDS) ? P_OVER : P_SPAWN;
                end
            end
            P_OVER: if (space) begin
                m_score = 0; m_misses = 0; m_round = 0; m_has_prev = 0; m_phase = P_SPAWN;
            end
            default: m_phase = P_IDLE;
        endcase
    endtask

    task automatic check_outputs(input string tag);
        logic [7:0] el = exp_light();
        logic       eg = (m_phase == P_OVER);
        checks++;
        if (bus.light !== el || bus.score !== m_score || bus.misses !== m_misses ||
            bus.round !== m_round || bus.game_over !== eg) begin
            errors++;
            $display("FAIL %s: got light=%h score=%0d misses=%0d round=%0d go=%b, expected light=%h score=%0d misses=%0d round=%0d go=%b",
                     tag, bus.light, bus.score, bus.misses, bus.round, bus.game_over,
                     el, m_score, m_misses, m_round, eg);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic step(input logic [15:0] kc, input logic fl, input string tag);
        bus.keycode = kc;
        bus.oflag   = fl;
        @(posedge clk);
        model_step(kc, fl);
        @(negedge clk);
        bus.oflag = 1'b0;
        check_outputs(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(16'h0000, 1'b0, tag);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs(tag);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [15:0] kc;
        logic        fl;
        logic [7:0]  exp_light;
        logic        exp_go;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          prev;
        logic [15:0] kc;
        logic        fl;

        vecs[0] = '{16'hF029, 1'b1, 8'h00, 1'b0};
        vecs[1] = '{16'h0029, 1'b0, 8'h00, 1'b0};
        vecs[2] = '{16'h001C, 1'b1, 8'h00, 1'b0};
        vecs[3] = '{16'h0016, 1'b1, 8'h00, 1'b0};
        vecs[4] = '{16'hF016, 1'b1, 8'h00, 1'b0};

        bus.keycode = 16'h0000;
        bus.oflag   = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_val("rst_light",  32'(bus.light),     32'h0);
        check_val("rst_score",  32'(bus.score),     32'h0);
        check_val("rst_misses", 32'(bus.misses),    32'h0);
        check_val("rst_round",  32'(bus.round),     32'h0);
        check_val("rst_go",     32'(bus.game_over), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            step(vecs[i].kc, vecs[i].fl, "idle_vec");
            check_val("idle_vec_light", 32'(bus.light), 32'(vecs[i].exp_light));
            check_val("idle_vec_go",    32'(bus.game_over), 32'(vecs[i].exp_go));
        end
        idle(2, "idle_settle");
        check_val("idle_no_start", 32'(bus.light), 32'h0);

        step(16'h0029, 1'b1, "start");
        step(16'h0000, 1'b0, "spawn");
        check_val("start_onehot", 32'($countones(bus.light)), 32'd1);

        step({8'h00, mole_keys[m_mole]}, 1'b1, "hit_key");
        check_val("hit_light", 32'(bus.light), 32'hFF);
        check_val("hit_score", 32'(bus.score), 32'd1);
        prev = m_mole;
        idle(4, "hit_pause");
        check_val("round1", 32'(bus.round), 32'd1);
        idle(1, "respawn");
        check_val("new_mole_differs", 32'(bus.light != (8'd1 << prev)), 32'd1);
        check_val("new_mole_onehot", 32'($countones(bus.light)), 32'd1);

        idle(19, "wait_lit");
        check_val("last_lit", 32'($countones(bus.light)), 32'd1);
        idle(1, "timeout");
        check_val("timeout_light",  32'(bus.light),  32'h0);
        check_val("timeout_misses", 32'(bus.misses), 32'd1);
        idle(5, "miss_pause");
        check_val("round2", 32'(bus.round), 32'd2);

        step(16'h001C, 1'b1, "other_key");
        check_val("other_ignored", 32'(bus.light), 32'(8'd1 << m_mole));
        idle(18, "to_last_cycle");
        step({8'h00, mole_keys[m_mole]}, 1'b1, "boundary_key");
        check_val("boundary_hit",    32'(bus.light),  32'hFF);
        check_val("boundary_misses", 32'(bus.misses), 32'd1);
        idle(4, "to_over");
        check_val("over_go",    32'(bus.game_over), 32'd1);
        check_val("over_light", 32'(bus.light),     32'd2);
        check_val("over_round", 32'(bus.round),     32'd3);

        step(16'h0029, 1'b1, "restart");
        check_val("restart_score", 32'(bus.score),     32'd0);
        check_val("restart_go",    32'(bus.game_over), 32'd0);
        idle(1, "restart_spawn");
        check_val("restart_onehot", 32'($countones(bus.light)), 32'd1);

        step({8'h00, mole_keys[(m_mole + 3) % 8]}, 1'b1, "wrong_key");
        check_val("wrong_light",  32'(bus.light),  32'h0);
        check_val("wrong_misses", 32'(bus.misses), 32'd1);
        idle(5, "wrong_pause");
        idle(7, "mid_up");

        do_reset("mid_reset");
        check_val("mid_reset_round", 32'(bus.round), 32'd0);
        step(16'h0029, 1'b1, "reseed_start");
        idle(1, "reseed_spawn");
        check_val("reseed_mole", 32'(bus.light), 32'(8'd1 << m_mole));

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset("rand_reset");
            end else begin
                case ($urandom_range(0, 5))
                    0:       kc = {8'h00, 8'h29};
                    1:       kc = {8'hF0, mole_keys[$urandom_range(0, 7)]};
                    2:       kc = {8'h00, 8'h1C};
                    3:       kc = 16'($urandom);
                    default: kc = {8'h00, mole_keys[$urandom_range(0, 7)]};
                endcase
                if (m_phase == P_UP && $urandom_range(0, 9) == 0) kc = {8'h00, mole_keys[m_mole]};
                fl = ($urandom_range(0, 3) == 0);
                step(kc, fl, "random");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
